// File: rtl/ovl_unchange_pkg.sv
// Shared types and constants for the unchange window checker: state encoding,
// fire bit positions and new-start policy codes.
package ovl_unchange_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WATCH  = 2'd1,
    FAILED = 2'd2
  } ovl_unchange_state_e;

  localparam int FIRE_CHANGE    = 0;
  localparam int FIRE_NEW_START = 1;
  localparam int FIRE_PARAM     = 2;

  // Same numeric values as the OVL library's *_NEW_START defines.
  localparam int OVL_IGNORE_NEW_START   = 0;
  localparam int OVL_RESET_ON_NEW_START = 1;
  localparam int OVL_ERROR_ON_NEW_START = 2;

  function automatic logic policy_legal(input int policy);
    return (policy == OVL_IGNORE_NEW_START) ||
           (policy == OVL_RESET_ON_NEW_START) ||
           (policy == OVL_ERROR_ON_NEW_START);
  endfunction

endpackage

// File: rtl/ovl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module ovl_sat_counter #(
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 inc,
  output logic [cnt_width-1:0] count
);

  localparam logic [cnt_width-1:0] ONE = {{(cnt_width-1){1'b0}}, 1'b1};

  logic [cnt_width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (clear) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ovl_unchange_window_checker.sv
// Unchange checking core fed by the upstream window logic; registered fire pulses
// and saturating statistics. Optional stats ports under OVL_UNCHANGE_STATS_EN.
//
// state  | meaning
// IDLE   | no window open, waiting for start_event
// WATCH  | window open, test_expr still equal to ref_value
// FAILED | window open, change already reported for this window
module ovl_unchange_window_checker
  import ovl_unchange_pkg::*;
#(
  parameter int width               = 8,
  parameter int cnt_width           = 16,
  parameter int action_on_new_start = OVL_IGNORE_NEW_START
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_event,
  input  logic [width-1:0]     test_expr,
  input  logic                 window,
  input  logic                 window_close,
  output logic [2:0]           fire,
  output logic [width-1:0]     ref_value,
  output logic [cnt_width-1:0] change_count,
  output logic [cnt_width-1:0] new_start_count,
  output logic                 failed
`ifdef OVL_UNCHANGE_STATS_EN
  ,
  output logic [cnt_width-1:0] window_count,
  output logic [cnt_width-1:0] max_fail_latency
`endif
);

  localparam logic PARAM_OK   = policy_legal(action_on_new_start);
  localparam logic POL_RESET  = (action_on_new_start == OVL_RESET_ON_NEW_START);
  localparam logic POL_ERROR  = (action_on_new_start == OVL_ERROR_ON_NEW_START);

  ovl_unchange_state_e state_q;
  logic [width-1:0]    ref_q;
  logic [2:0]          fire_q;
  logic                failed_q;
  logic                init_done_q;

  logic active, changed, new_start_err, restart, open_win;

  always_comb begin
    active        = (state_q != IDLE) && window;
    // X/Z on test_expr must count as a change, hence the case inequality.
    changed       = active && (state_q == WATCH) && (test_expr !== ref_q);
    new_start_err = active && start_event && POL_ERROR;
    restart       = active && start_event && POL_RESET;
    open_win      = (state_q == IDLE) && start_event && !window;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ref_q       <= '0;
      fire_q      <= '0;
      failed_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      init_done_q            <= 1'b1;
      fire_q[FIRE_CHANGE]    <= changed;
      fire_q[FIRE_NEW_START] <= new_start_err;
      fire_q[FIRE_PARAM]     <= !PARAM_OK && !init_done_q;
      unique case (state_q)
        IDLE: begin
          if (open_win) begin
            ref_q    <= test_expr;
            state_q  <= WATCH;
            failed_q <= 1'b0;
          end
        end
        WATCH, FAILED: begin
          // A restart takes priority over window_close: the window is extended.
          if (!window) begin
            state_q  <= IDLE;
            failed_q <= 1'b0;
          end else if (restart) begin
            ref_q    <= test_expr;
            state_q  <= WATCH;
            failed_q <= 1'b0;
          end else if (window_close) begin
            state_q  <= IDLE;
            failed_q <= 1'b0;
          end else if (changed) begin
            state_q  <= FAILED;
            failed_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          failed_q <= 1'b0;
        end
      endcase
    end
  end

  ovl_sat_counter #(.cnt_width(cnt_width)) u_change_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (changed),
    .count (change_count)
  );

  ovl_sat_counter #(.cnt_width(cnt_width)) u_new_start_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (new_start_err),
    .count (new_start_count)
  );

  assign fire      = fire_q;
  assign ref_value = ref_q;
  assign failed    = failed_q;

`ifdef OVL_UNCHANGE_STATS_EN
  localparam logic [cnt_width-1:0] LAT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

  logic [cnt_width-1:0] lat_q, lat_inc, max_lat_q;

  ovl_sat_counter #(.cnt_width(cnt_width)) u_window_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (open_win),
    .count (window_count)
  );

  // lat_inc is the 1-based position of the current window cycle.
  always_comb begin
    lat_inc = (lat_q == '1) ? lat_q : lat_q + LAT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_q     <= '0;
      max_lat_q <= '0;
    end else begin
      if (open_win || restart)              lat_q <= '0;
      else if (active && state_q == WATCH)  lat_q <= lat_inc;
      if (changed && (lat_inc > max_lat_q)) max_lat_q <= lat_inc;
    end
  end

  assign max_fail_latency = max_lat_q;
`endif

endmodule

// File: tb/tb_ovl_unchange_window_checker.sv
// Directed bench for ovl_unchange_window_checker: one shared stimulus stream
// drives instances with IGNORE, ERROR, RESET and illegal policies plus a 2-bit counter build.
module tb_ovl_unchange_window_checker;
  import ovl_unchange_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_event;
  logic [7:0] test_expr;
  logic       window;
  logic       window_close;

  logic [2:0]  ign_fire,  err_fire,  rst_fire,  sat_fire,  bad_fire;
  logic [7:0]  ign_ref,   err_ref,   rst_ref,   sat_ref,   bad_ref;
  logic [15:0] ign_cc,    err_cc,    rst_cc,    bad_cc;
  logic [15:0] ign_nc,    err_nc,    rst_nc,    bad_nc;
  logic [1:0]  sat_cc,    sat_nc;
  logic        ign_failed, err_failed, rst_failed, sat_failed, bad_failed;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ovl_unchange_window_checker #(.width(8), .cnt_width(16), .action_on_new_start(OVL_IGNORE_NEW_START)) u_ign (
    .clk(clk), .reset(reset), .start_event(start_event), .test_expr(test_expr), .window(window),
    .window_close(window_close), .fire(ign_fire), .ref_value(ign_ref), .change_count(ign_cc),
    .new_start_count(ign_nc), .failed(ign_failed));

  ovl_unchange_window_checker #(.width(8), .cnt_width(16), .action_on_new_start(OVL_ERROR_ON_NEW_START)) u_err (
    .clk(clk), .reset(reset), .start_event(start_event), .test_expr(test_expr), .window(window),
    .window_close(window_close), .fire(err_fire), .ref_value(err_ref), .change_count(err_cc),
    .new_start_count(err_nc), .failed(err_failed));

  ovl_unchange_window_checker #(.width(8), .cnt_width(16), .action_on_new_start(OVL_RESET_ON_NEW_START)) u_rst (
    .clk(clk), .reset(reset), .start_event(start_event), .test_expr(test_expr), .window(window),
    .window_close(window_close), .fire(rst_fire), .ref_value(rst_ref), .change_count(rst_cc),
    .new_start_count(rst_nc), .failed(rst_failed));

  ovl_unchange_window_checker #(.width(8), .cnt_width(2), .action_on_new_start(OVL_IGNORE_NEW_START)) u_sat (
    .clk(clk), .reset(reset), .start_event(start_event), .test_expr(test_expr), .window(window),
    .window_close(window_close), .fire(sat_fire), .ref_value(sat_ref), .change_count(sat_cc),
    .new_start_count(sat_nc), .failed(sat_failed));

  ovl_unchange_window_checker #(.width(8), .cnt_width(16), .action_on_new_start(7)) u_bad (
    .clk(clk), .reset(reset), .start_event(start_event), .test_expr(test_expr), .window(window),
    .window_close(window_close), .fire(bad_fire), .ref_value(bad_ref), .change_count(bad_cc),
    .new_start_count(bad_nc), .failed(bad_failed));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] t, input logic w, input logic c);
    start_event  = s;
    test_expr    = t;
    window       = w;
    window_close = c;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_fire",    ign_fire,   3'b000);
    chk("rst_ref",     ign_ref,    8'h00);
    chk("rst_cc",      ign_cc,     16'd0);
    chk("rst_nc",      ign_nc,     16'd0);
    chk("rst_failed",  ign_failed, 1'b0);
    chk("rst_badfire", bad_fire,   3'b000);

    // First cycle after reset release: illegal policy pulses fire[2] once
    reset = 1'b0;
    tick();
    chk("param_pulse", bad_fire, 3'b100);
    chk("param_legal", ign_fire, 3'b000);
    tick();
    chk("param_once",  bad_fire, 3'b000);

    // Window held stable at 5A
    drive(1'b1, 8'h5A, 1'b0, 1'b0); tick();
    chk("hold_ref", ign_ref, 8'h5A);
    drive(1'b0, 8'h5A, 1'b1, 1'b0); tick();
    chk("hold_f1", ign_fire, 3'b000);
    drive(1'b0, 8'h5A, 1'b1, 1'b0); tick();
    chk("hold_f2", ign_fire, 3'b000);
    drive(1'b0, 8'h5A, 1'b1, 1'b1); tick();
    chk("hold_f3", ign_fire, 3'b000);
    // Back in IDLE: a stray window with a different value must not fire
    drive(1'b0, 8'hFF, 1'b1, 1'b0); tick();
    chk("idle_probe", ign_fire, 3'b000);
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    chk("idle_probe2", ign_fire, 3'b000);

    // Change inside the window: single fire[0]
    drive(1'b1, 8'h5A, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h5A, 1'b1, 1'b0); tick();
    chk("chg_none", ign_fire, 3'b000);
    drive(1'b0, 8'h5B, 1'b1, 1'b0); tick();
    chk("chg_fire",   ign_fire,   3'b001);
    chk("chg_cc",     ign_cc,     16'd1);
    chk("chg_failed", ign_failed, 1'b1);
    drive(1'b0, 8'h5C, 1'b1, 1'b1); tick();
    chk("chg_once",    ign_fire,   3'b000);
    chk("chg_cc2",     ign_cc,     16'd1);
    chk("chg_end",     ign_failed, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();

    // ERROR policy: new start mid-window
    drive(1'b1, 8'h11, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h11, 1'b1, 1'b0); tick();
    drive(1'b1, 8'h11, 1'b1, 1'b0); tick();
    chk("err_fire",    err_fire, 3'b010);
    chk("err_nc",      err_nc,   16'd1);
    chk("ign_nofire",  ign_fire, 3'b000);
    chk("ign_nc",      ign_nc,   16'd0);
    drive(1'b0, 8'h11, 1'b1, 1'b1); tick();
    chk("err_fire_end", err_fire, 3'b000);
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    chk("err_idle", err_fire, 3'b000);

    // RESET policy: restart from FAILED with 33
    drive(1'b1, 8'h22, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h44, 1'b1, 1'b0); tick();
    chk("rst_chg_fire", rst_fire,   3'b001);
    chk("rst_chg_fail", rst_failed, 1'b1);
    drive(1'b1, 8'h33, 1'b1, 1'b0); tick();
    chk("rst_ref33",    rst_ref,    8'h33);
    chk("rst_rewatch",  rst_failed, 1'b0);
    chk("rst_nofire",   rst_fire,   3'b000);
    chk("ign_ref22",    ign_ref,    8'h22);
    chk("ign_stillf",   ign_failed, 1'b1);
    chk("err_fire2",    err_fire,   3'b010);
    chk("err_nc2",      err_nc,     16'd2);
    drive(1'b0, 8'h33, 1'b1, 1'b0); tick();
    chk("rst_hold33",   rst_fire,   3'b000);
    drive(1'b0, 8'h34, 1'b1, 1'b0); tick();
    chk("rst_fire34",   rst_fire,   3'b001);
    chk("rst_cc3",      rst_cc,     16'd3);
    chk("rst_fail34",   rst_failed, 1'b1);
    chk("ign_cc2",      ign_cc,     16'd2);
    chk("ign_f_quiet",  ign_fire,   3'b000);

    // Synchronous reset while in FAILED
    reset = 1'b1;
    drive(1'b0, 8'h35, 1'b1, 1'b0); tick();
    chk("mid_rst_failed", rst_failed, 1'b0);
    chk("mid_rst_cc",     rst_cc,     16'd0);
    chk("mid_rst_nc",     err_nc,     16'd0);
    chk("mid_rst_fire",   rst_fire,   3'b000);
    chk("mid_rst_ref",    rst_ref,    8'h00);
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    chk("mid_rst_param", bad_fire, 3'b100);
    drive(1'b0, 8'hFF, 1'b1, 1'b0); tick();
    chk("mid_rst_idle", rst_fire, 3'b000);
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();

    // Five violating windows: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h00, 1'b0, 1'b0); tick();
      drive(1'b0, 8'h01, 1'b1, 1'b0); tick();
      chk("sat_fire", sat_fire, 3'b001);
      drive(1'b0, 8'h01, 1'b1, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
      chk("sat_cc", sat_cc, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      chk("ign_cc_run", ign_cc, 32'(i + 1));
    end

    // Change and illegal new start in the same cycle
    drive(1'b1, 8'hAA, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hAB, 1'b1, 1'b0); tick();
    chk("both_fire", err_fire, 3'b011);
    chk("both_cc",   err_cc,   16'd6);
    chk("both_nc",   err_nc,   16'd1);
    drive(1'b0, 8'hAB, 1'b1, 1'b1); tick();
    chk("both_quiet", err_fire, 3'b000);
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
